// File: rtl/glip_uart_phy.sv
// glip_uart_phy: single-clock UART transceiver for the GLIP UART backend.
//
// Frame format (data bits, parity, stop bits) is fixed by parameters; the baud divisor is a
// runtime input that is latched at every frame start (TX and RX independently).
//
// Ports:
//   clk, nreset            clock, asynchronous active-low reset
//   divisor                clk cycles per bit (0 and 1 behave as 2)
//   tx_data/valid/ready    TX byte handshake; ready rises once the frame has fully left
//   rx_data/valid/ready    first-word fall-through RX FIFO head, popped on valid & ready
//   uart_rx, uart_tx       serial pins
//   uart_cts_n, uart_rts_n hardware flow control (active low)
//   rx_level               RX FIFO fill level
//   err_frame/parity/overrun  one-cycle error pulses; error is their sticky OR
//
// Optional build macro GLIP_UART_PHY_LOOPBACK_EN adds input 'loopback', which routes the
// internal TX serial line into the RX path, holds uart_tx high and ignores CTS.
module glip_uart_phy #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned DIV_WIDTH  = 16,
  parameter int unsigned RX_DEPTH   = 16,
  parameter int unsigned RTS_MARGIN = 4
) (
  input  logic                        clk,
  input  logic                        nreset,
`ifdef GLIP_UART_PHY_LOOPBACK_EN
  input  logic                        loopback,
`endif
  input  logic [DIV_WIDTH-1:0]        divisor,
  input  logic [7:0]                  tx_data,
  input  logic                        tx_valid,
  output logic                        tx_ready,
  output logic [7:0]                  rx_data,
  output logic                        rx_valid,
  input  logic                        rx_ready,
  input  logic                        uart_rx,
  output logic                        uart_tx,
  input  logic                        uart_cts_n,
  output logic                        uart_rts_n,
  output logic [$clog2(RX_DEPTH):0]   rx_level,
  output logic                        err_frame,
  output logic                        err_parity,
  output logic                        err_overrun,
  output logic                        error
);

  localparam int unsigned AW = $clog2(RX_DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam logic [2:0]    LastData = 3'(DATA_BITS - 1);
  localparam logic [2:0]    LastStop = 3'(STOP_BITS - 1);
  localparam logic [AW:0]   FullLvl  = LW'(RX_DEPTH);
  localparam logic [AW:0]   RtsLvl   = LW'(RX_DEPTH - RTS_MARGIN);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  // Input synchronisers; idle-high line and "CTS not granted" out of reset.
  logic rx_s1_q, rx_s2_q, cts_s1_q, cts_s2_q;
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      rx_s1_q  <= 1'b1;
      rx_s2_q  <= 1'b1;
      cts_s1_q <= 1'b1;
      cts_s2_q <= 1'b1;
    end else begin
      rx_s1_q  <= uart_rx;
      rx_s2_q  <= rx_s1_q;
      cts_s1_q <= uart_cts_n;
      cts_s2_q <= cts_s1_q;
    end
  end

  logic [DIV_WIDTH-1:0] div_eff;
  assign div_eff = (divisor < DIV_WIDTH'(2)) ? DIV_WIDTH'(2) : divisor;

  logic tx_q, rx_line, cts_ok;
`ifdef GLIP_UART_PHY_LOOPBACK_EN
  assign rx_line = loopback ? tx_q : rx_s2_q;
  assign cts_ok  = loopback | ~cts_s2_q;
  assign uart_tx = tx_q | loopback;
`else
  assign rx_line = rx_s2_q;
  assign cts_ok  = ~cts_s2_q;
  assign uart_tx = tx_q;
`endif

  // ---------------------------------------------------------------- TX
  state_e               tx_state_q;
  logic [7:0]           tx_hold_q;
  logic                 tx_full_q, tx_ready_q;
  logic [DIV_WIDTH-1:0] tx_div_q, tx_cnt_q;
  logic [2:0]           tx_idx_q;
  logic                 tx_par, tx_bit_end;

  assign tx_par     = (PARITY == 1) ? ~^tx_hold_q[DATA_BITS-1:0] : ^tx_hold_q[DATA_BITS-1:0];
  assign tx_bit_end = (tx_cnt_q == tx_div_q - DIV_WIDTH'(1));
  assign tx_ready   = tx_ready_q;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      tx_state_q <= StIdle;
      tx_q       <= 1'b1;
      tx_ready_q <= 1'b0;
      tx_full_q  <= 1'b0;
      tx_hold_q  <= '0;
      tx_div_q   <= DIV_WIDTH'(2);
      tx_cnt_q   <= '0;
      tx_idx_q   <= '0;
    end else begin
      if (tx_valid && tx_ready_q) begin
        tx_hold_q  <= tx_data;
        tx_full_q  <= 1'b1;
        tx_ready_q <= 1'b0;
      end else if (tx_state_q == StIdle && !tx_full_q) begin
        tx_ready_q <= 1'b1;
      end
      if (tx_state_q != StIdle) tx_cnt_q <= tx_bit_end ? '0 : tx_cnt_q + DIV_WIDTH'(1);
      case (tx_state_q)
        StIdle: begin
          // CTS only gates frame starts, so a running frame is never cut short.
          if (tx_full_q && cts_ok) begin
            tx_state_q <= StStart;
            tx_q       <= 1'b0;
            tx_div_q   <= div_eff;
            tx_cnt_q   <= '0;
          end
        end
        StStart: begin
          if (tx_bit_end) begin
            tx_state_q <= StData;
            tx_idx_q   <= '0;
            tx_q       <= tx_hold_q[0];
          end
        end
        StData: begin
          if (tx_bit_end) begin
            if (tx_idx_q == LastData) begin
              tx_idx_q <= '0;
              if (PARITY != 0) begin
                tx_state_q <= StParity;
                tx_q       <= tx_par;
              end else begin
                tx_state_q <= StStop;
                tx_q       <= 1'b1;
              end
            end else begin
              tx_idx_q <= tx_idx_q + 3'd1;
              tx_q     <= tx_hold_q[tx_idx_q + 3'd1];
            end
          end
        end
        StParity: begin
          if (tx_bit_end) begin
            tx_state_q <= StStop;
            tx_q       <= 1'b1;
          end
        end
        StStop: begin
          if (tx_bit_end) begin
            if (tx_idx_q == LastStop) begin
              tx_state_q <= StIdle;
              tx_full_q  <= 1'b0;
              tx_ready_q <= 1'b1;
            end else begin
              tx_idx_q <= tx_idx_q + 3'd1;
            end
          end
        end
        default: tx_state_q <= StIdle;
      endcase
    end
  end

  // ---------------------------------------------------------------- RX
  state_e               rx_state_q;
  logic [DIV_WIDTH-1:0] rx_div_q, rx_cnt_q;
  logic [2:0]           rx_idx_q;
  logic [7:0]           rx_shift_q;
  logic                 rx_prev_q, rx_par_err_q;
  logic                 err_frame_q, err_parity_q, err_overrun_q, error_q;
  logic                 rx_bit_end, rx_half, rx_exp_par, rx_push;
  logic                 fifo_full, fifo_pop;

  assign rx_bit_end = (rx_cnt_q == rx_div_q - DIV_WIDTH'(1));
  assign rx_half    = (rx_cnt_q == (rx_div_q >> 1) - DIV_WIDTH'(1));
  assign rx_exp_par = (PARITY == 1) ? ~^rx_shift_q[DATA_BITS-1:0] : ^rx_shift_q[DATA_BITS-1:0];
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the frame.
  assign rx_push    = (rx_state_q == StStop) && rx_bit_end && rx_line && !rx_par_err_q &&
                      (!fifo_full || fifo_pop);

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      rx_state_q    <= StIdle;
      rx_div_q      <= DIV_WIDTH'(2);
      rx_cnt_q      <= '0;
      rx_idx_q      <= '0;
      rx_shift_q    <= '0;
      rx_prev_q     <= 1'b1;
      rx_par_err_q  <= 1'b0;
      err_frame_q   <= 1'b0;
      err_parity_q  <= 1'b0;
      err_overrun_q <= 1'b0;
      error_q       <= 1'b0;
    end else begin
      rx_prev_q     <= rx_line;
      err_frame_q   <= 1'b0;
      err_parity_q  <= 1'b0;
      err_overrun_q <= 1'b0;
      if (rx_state_q != StIdle) begin
        rx_cnt_q <= ((rx_state_q == StStart) ? rx_half : rx_bit_end) ? '0
                                                                     : rx_cnt_q + DIV_WIDTH'(1);
      end
      case (rx_state_q)
        StIdle: begin
          // Edge rather than level: after a frame error the line must go high to re-arm.
          if (rx_prev_q && !rx_line) begin
            rx_state_q   <= StStart;
            rx_div_q     <= div_eff;
            rx_cnt_q     <= '0;
            rx_idx_q     <= '0;
            rx_shift_q   <= '0;
            rx_par_err_q <= 1'b0;
          end
        end
        StStart: if (rx_half) rx_state_q <= rx_line ? StIdle : StData;
        StData: begin
          if (rx_bit_end) begin
            rx_shift_q[rx_idx_q] <= rx_line;
            if (rx_idx_q == LastData) begin
              rx_idx_q   <= '0;
              rx_state_q <= (PARITY != 0) ? StParity : StStop;
            end else begin
              rx_idx_q <= rx_idx_q + 3'd1;
            end
          end
        end
        StParity: begin
          if (rx_bit_end) begin
            rx_par_err_q <= (rx_line != rx_exp_par);
            rx_state_q   <= StStop;
          end
        end
        StStop: begin
          // Only the first stop bit is checked; idling here lets a start in stop 2 be seen.
          if (rx_bit_end) begin
            rx_state_q <= StIdle;
            if (!rx_line) begin
              err_frame_q <= 1'b1;
              error_q     <= 1'b1;
            end else if (rx_par_err_q) begin
              err_parity_q <= 1'b1;
              error_q      <= 1'b1;
            end else if (!rx_push) begin
              err_overrun_q <= 1'b1;
              error_q       <= 1'b1;
            end
          end
        end
        default: rx_state_q <= StIdle;
      endcase
    end
  end

  assign err_frame   = err_frame_q;
  assign err_parity  = err_parity_q;
  assign err_overrun = err_overrun_q;
  assign error       = error_q;

  // ---------------------------------------------------------------- RX FIFO
  logic [7:0]  mem_q [RX_DEPTH];
  logic [AW:0] wr_ptr_q, rd_ptr_q;
  logic        rts_q;

  assign rx_level   = wr_ptr_q - rd_ptr_q;
  assign fifo_full  = (rx_level == FullLvl);
  assign rx_valid   = (rx_level != '0);
  assign fifo_pop   = rx_valid & rx_ready;
  assign rx_data    = rx_valid ? mem_q[rd_ptr_q[AW-1:0]] : '0;
  assign uart_rts_n = rts_q;

  always_ff @(posedge clk) begin
    if (rx_push) mem_q[wr_ptr_q[AW-1:0]] <= rx_shift_q;
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      rts_q    <= 1'b0;
    end else begin
      if (rx_push)  wr_ptr_q <= wr_ptr_q + LW'(1);
      if (fifo_pop) rd_ptr_q <= rd_ptr_q + LW'(1);
      rts_q <= (rx_level >= RtsLvl);
    end
  end

endmodule

// File: tb/tb_glip_uart_phy.sv
module tb_glip_uart_phy;
  localparam int unsigned D  = 16;
  localparam int unsigned D7 = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        nreset;
  logic [15:0] divisor;
  logic [7:0]  tx_data, rx_data;
  logic        tx_valid, tx_ready, rx_valid, rx_ready;
  logic        uart_rx, uart_tx, uart_cts_n, uart_rts_n;
  logic [4:0]  rx_level;
  logic        err_frame, err_parity, err_overrun, error;

  // Second instance at 7O2 with its serial pins tied together.
  logic [7:0]  tx7_data, rx7_data;
  logic        tx7_valid, tx7_ready, rx7_valid, l7_line, rts7_n;
  logic [4:0]  rx7_level;
  logic        e7_frame, e7_parity, e7_overrun, error7;

  glip_uart_phy #(
    .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .DIV_WIDTH(16), .RX_DEPTH(16), .RTS_MARGIN(4)
  ) u_dut (
    .clk(clk), .nreset(nreset),
`ifdef GLIP_UART_PHY_LOOPBACK_EN
    .loopback(1'b0),
`endif
    .divisor(divisor), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready), .uart_rx(uart_rx),
    .uart_tx(uart_tx), .uart_cts_n(uart_cts_n), .uart_rts_n(uart_rts_n), .rx_level(rx_level),
    .err_frame(err_frame), .err_parity(err_parity), .err_overrun(err_overrun), .error(error)
  );

  glip_uart_phy #(
    .DATA_BITS(7), .PARITY(1), .STOP_BITS(2), .DIV_WIDTH(16), .RX_DEPTH(16), .RTS_MARGIN(4)
  ) u_dut7 (
    .clk(clk), .nreset(nreset),
`ifdef GLIP_UART_PHY_LOOPBACK_EN
    .loopback(1'b0),
`endif
    .divisor(16'(D7)), .tx_data(tx7_data), .tx_valid(tx7_valid), .tx_ready(tx7_ready),
    .rx_data(rx7_data), .rx_valid(rx7_valid), .rx_ready(1'b1), .uart_rx(l7_line),
    .uart_tx(l7_line), .uart_cts_n(1'b0), .uart_rts_n(rts7_n), .rx_level(rx7_level),
    .err_frame(e7_frame), .err_parity(e7_parity), .err_overrun(e7_overrun), .error(error7)
  );

  int total = 0;
  int bad   = 0;
  int n_par = 0, n_frm = 0, n_ovr = 0, n_txlow = 0, n7_err = 0;
  logic [7:0] sb_q[$];

  always @(negedge clk) begin
    if (err_parity) n_par++;
    if (err_frame) n_frm++;
    if (err_overrun) n_ovr++;
    if (!uart_tx) n_txlow++;
    if (e7_frame || e7_parity || e7_overrun) n7_err++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Drive one 8E1 frame onto uart_rx; a bad stop bit leaves the line low afterwards.
  task automatic inject(input logic [7:0] d, input bit flip_par, input bit bad_stop);
    uart_rx = 1'b0;
    ticks(D);
    for (int i = 0; i < 8; i++) begin
      uart_rx = d[i];
      ticks(D);
    end
    uart_rx = (^d) ^ flip_par;
    ticks(D);
    uart_rx = !bad_stop;
    ticks(D);
  endtask

  function automatic logic exp_bit(input logic [7:0] d, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return d[k-1];
    if (k == 9) return ^d;
    return 1'b1;
  endfunction

  initial begin
    logic [7:0] b, ex;
    int c0;
    nreset = 1'b0; divisor = 16'(D); tx_data = '0; tx_valid = 1'b0; rx_ready = 1'b0;
    uart_rx = 1'b1; uart_cts_n = 1'b0; tx7_data = '0; tx7_valid = 1'b0;
    ticks(3);
    check("rst_uart_tx", uart_tx, 1);
    check("rst_rts_n", uart_rts_n, 0);
    check("rst_tx_ready", tx_ready, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_rx_level", rx_level, 0);
    check("rst_error", error, 0);
    nreset = 1'b1;
    tick();
    check("tx_ready_after_rst", tx_ready, 1);

    // TX framing: 0xA5 at 8E1.
    tx_data = 8'hA5; tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    for (int i = 0; i < 20 && uart_tx; i++) tick();
    check("tx_start_seen", uart_tx, 0);
    c0 = 0;
    for (int k = 0; k < 11; k++) begin
      ticks(8);
      check($sformatf("tx_bit%0d", k), uart_tx, exp_bit(8'hA5, k));
      check($sformatf("tx_busy%0d", k), tx_ready, 0);
      if (k < 10) ticks(8);
    end
    ticks(7);
    check("tx_ready_at_175", tx_ready, 0);
    tick();
    check("tx_ready_at_176", tx_ready, 1);

    // One good received byte.
    inject(8'h96, 1'b0, 1'b0);
    sb_q.push_back(8'h96);
    check("rx1_level", rx_level, 1);
    ex = sb_q.pop_front();
    check("rx1_data", {rx_valid, rx_data}, {1'b1, ex});
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
    check("rx1_popped", rx_level, 0);
    check("no_error_yet", error, 0);

    // Parity error.
    c0 = n_par;
    inject(8'h3C, 1'b1, 1'b0);
    ticks(4);
    check("par_pulses", n_par - c0, 1);
    check("par_sticky", error, 1);
    check("par_level", rx_level, 0);

    // Frame error; the line stays low, nothing may be received until it returns high.
    c0 = n_frm;
    inject(8'h55, 1'b0, 1'b1);
    ticks(100);
    check("frm_pulses", n_frm - c0, 1);
    check("frm_level", rx_level, 0);
    uart_rx = 1'b1;
    ticks(20);
    inject(8'h33, 1'b0, 1'b0);
    sb_q.push_back(8'h33);
    check("frm_no_more", n_frm - c0, 1);
    ex = sb_q.pop_front();
    check("frm_recover", {rx_valid, rx_data}, {1'b1, ex});
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;

    // Flow control and overrun.
    c0 = n_ovr;
    for (int i = 1; i <= 17; i++) begin
      b = 8'($urandom_range(0, 255));
      inject(b, 1'b0, 1'b0);
      if (i <= 16) sb_q.push_back(b);
      if (i == 11) check("rts_at_11", uart_rts_n, 0);
      if (i == 12) check("rts_at_12", uart_rts_n, 1);
      if (i == 16) check("full_level", rx_level, 16);
      if (i == 16) check("no_ovr_yet", n_ovr - c0, 0);
    end
    check("ovr_pulse", n_ovr - c0, 1);
    check("ovr_level", rx_level, 16);
    for (int i = 0; i < 16; i++) begin
      ex = sb_q.pop_front();
      check($sformatf("drain%0d", i), {rx_valid, rx_data}, {1'b1, ex});
      rx_ready = 1'b1;
      tick();
      rx_ready = 1'b0;
    end
    tick();
    check("drained", rx_level, 0);
    check("rts_released", uart_rts_n, 0);

    // CTS blocks transmission; then reset mid-DATA.
    uart_cts_n = 1'b1;
    ticks(3);
    c0 = n_txlow;
    tx_data = 8'h81; tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    check("cts_accepted", tx_ready, 0);
    inject(8'h44, 1'b0, 1'b0);
    check("cts_rx_level", rx_level, 1);
    ticks(1000 - 1 - 11 * D);
    check("cts_tx_idle", n_txlow - c0, 0);
    uart_cts_n = 1'b0;
    for (int i = 0; i < 10 && uart_tx; i++) tick();
    check("cts_start", uart_tx, 0);
    ticks(40);
    check("mid_data_bit", uart_tx, 0);
    nreset = 1'b0;
    #1;
    check("rst_tx_high", uart_tx, 1);
    check("rst_fifo_empty", rx_level, 0);
    ticks(3);
    nreset = 1'b1;
    tick();
    check("rst_tx_ready", tx_ready, 1);
    check("rst_rx_valid2", rx_valid, 0);

    // 7O2 pin loopback at divisor 10; bit 7 of tx_data must be ignored.
    for (int i = 0; i < 128; i++) begin
      for (int w = 0; w < 300 && !tx7_ready; w++) tick();
      tx7_data = 8'(i) | (i[0] ? 8'h80 : 8'h00);
      tx7_valid = 1'b1;
      sb_q.push_back(8'(i));
      tick();
      tx7_valid = 1'b0;
      for (int w = 0; w < 300 && !rx7_valid; w++) tick();
      ex = sb_q.pop_front();
      check($sformatf("lb%0d", i), {rx7_valid, rx7_data}, {1'b1, ex});
    end
    ticks(30);
    check("lb_no_errors", n7_err, 0);
    check("lb_error_flag", error7, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/glip_uart_phy.md
Name: glip_uart_phy

Overview:
- Vendor-independent, single-clock UART transceiver.
- Serves as the next generation of the 8N1 receive/transmit pair used by the GLIP UART backend.
- Frame format is parametrised (data bits, parity, stop bits); the baud divisor is set at runtime.
- Contains an internal RX FIFO that drives RTS flow control, and a TX holding register that is gated by CTS.
- Sits between the UART pins and the GLIP control logic, in the same clock domain as clk_io.

Parameters:
- DATA_BITS, 8: payload bits per frame. Legal values 5..8; LSB is sent first.
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: 1 or 2.
- DIV_WIDTH, 16: width of the baud divisor input.
- RX_DEPTH, 16: RX FIFO entries. Power of two, at least 4.
- RTS_MARGIN, 4: free entries remaining at which rts_n is deasserted. Range 1..RX_DEPTH-1.

Ports:
- clk, input, 1: I/O clock.
- nreset, input, 1: asynchronous active-low reset.
- divisor, input, DIV_WIDTH: clk cycles per bit. Values 0 and 1 are treated as 2.
- tx_data, input, 8: byte to send. Bits above DATA_BITS-1 are ignored.
- tx_valid, input, 1: tx_data is valid.
- tx_ready, output, 1: TX holding register is empty.
- rx_data, output, 8: received byte, zero-extended above DATA_BITS.
- rx_valid, output, 1: RX FIFO is not empty.
- rx_ready, input, 1: pops the RX FIFO head.
- uart_rx, input, 1: serial in. Asynchronous to clk.
- uart_tx, output, 1: serial out.
- uart_cts_n, input, 1: active low; the host permits transmission.
- uart_rts_n, output, 1: active low; this block permits the host to send.
- rx_level, output, clog2(RX_DEPTH)+1: current RX FIFO fill level.
- err_frame, output, 1: one-cycle pulse when a stop bit is sampled low.
- err_parity, output, 1: one-cycle pulse on parity mismatch.
- err_overrun, output, 1: one-cycle pulse when a frame is dropped because the FIFO is full.
- error, output, 1: sticky OR of the three error pulses. Cleared only by reset.

Behaviour:
- Reset state: all outputs are 0 except uart_tx=1 and uart_rts_n=0. tx_ready is 1 one cycle after reset release. FIFO is empty and both FSMs are IDLE.
- uart_rx passes through a 2-flop synchroniser before any use. It adds 2 cycles of latency on every edge.
- Divisor handling: the effective divisor D is latched at each frame start (TX and RX separately). A divisor change mid-frame takes effect on the next frame.
- TX handshake: the byte is accepted on tx_valid & tx_ready. tx_ready drops on the next cycle and rises when the FSM enters IDLE after the last stop bit. This allows back-to-back frames with zero idle bits.
- TX FSM: IDLE -> START -> DATA (DATA_BITS bits) -> PARITY (only if PARITY!=0) -> STOP (STOP_BITS bits) -> IDLE. Each bit lasts exactly D cycles.
- TX start rule: leave IDLE only when the holding register is full and the synchronised uart_cts_n is 0. uart_cts_n is sampled only in IDLE, so deasserting it mid-frame never truncates a frame.
- Parity: odd parity is the complement of the XOR over the data bits; even parity is the XOR itself.
- RX FSM: IDLE -> START -> DATA -> PARITY (if enabled) -> STOP -> IDLE.
- RX start detection: a falling edge in IDLE starts a counter. At D/2 (floor) cycles the line is checked. If it is high, the start is a glitch and the FSM returns to IDLE with no error. If it is low, each subsequent bit is sampled every D cycles, at mid-bit.
- RX STOP: only the first stop bit is checked. At its sample point the FSM returns to IDLE, so it can catch a start bit in the second stop period.
- Frame error: stop bit sampled 0. Pulse err_frame and discard the byte. The FSM waits in IDLE for the line to return high before arming again.
- Parity error: pulse err_parity at the stop sample and discard the byte.
- Overrun: a valid frame arriving while the FIFO is full is dropped and err_overrun pulses. A simultaneous push and pop on a full FIFO is accepted.
- FIFO: first-word fall-through, so rx_data is valid when rx_valid=1. A pushed byte appears at the output 1 cycle after the push.
- FIFO pointers: DEPTH-sized with a wrap bit. A simultaneous push and pop keeps the level unchanged.
- RTS: uart_rts_n is registered; it is 1 when rx_level >= RX_DEPTH-RTS_MARGIN and 0 otherwise.
- Asynchronous reset mid-frame: uart_tx goes high immediately and the partial frame is lost. A partially received byte is discarded with no error pulse.

Optional Feature:
- Macro: GLIP_UART_PHY_LOOPBACK_EN.
- When the macro is defined:
  - An extra input `loopback` (1 bit) exists.
  - When loopback=1, the RX path takes the internal TX serial signal instead of uart_rx, bypassing the synchroniser. uart_tx is held at 1, and CTS is treated as asserted.
  - Switching loopback is legal only when both FSMs are IDLE.
- When the macro is undefined: the port and the mux are absent, and the RX path always uses synchronised uart_rx.

Test Plan:
- Byte framing, 8E1: divisor=16, tx 0xA5, cts_n=0 -> uart_tx shows low for 16 cycles, then bits 1,0,1,0,0,1,0,1, parity 0, stop 1, each 16 cycles. tx_ready returns after 176 cycles.
- Loopback of pins at 7O2, divisor=10: uart_tx wired to uart_rx, send 0x00..0x7F -> rx_data matches every byte, with no error pulses.
- Parity error, 8E1: inject 0x3C with the parity bit flipped -> err_parity pulses once, error=1, FIFO level unchanged.
- Frame error: inject 0x55 with the stop bit low -> err_frame pulses. No further frame is received until the line is high.
- Flow control, RX_DEPTH=16, RTS_MARGIN=4: receive 12 bytes with rx_ready=0 -> rts_n=1 after the 12th. At 16 bytes, a 17th byte pulses err_overrun and the first 16 bytes read back intact.
- CTS and reset: cts_n=1 with tx_valid held -> uart_tx stays 1 for 1000 cycles. Drop cts_n, then assert nreset low mid-DATA -> uart_tx=1 immediately, tx_ready=1 after release, and the FIFO is empty.
